// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM encoding and default sizing.
package seq_pkg;

  // State names carry an S_ prefix so they never collide with the GAP parameter.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_GAP   = 1;
  localparam int DEF_REPW  = 4;

endpackage

// File: rtl/seq_gen_shift.sv
// Pattern shift register for seq_gen: parallel load, MSB-first left shift,
// and a saved copy of the loaded pattern so repeated frames can be resent.
module seq_shift
  import seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             shift,
  input  logic             reload,
  output logic             msb
);

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] saved;

  // A new load always wins; a reload restores the pattern captured at the last load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg <= '0;
      saved <= '0;
    end else if (load) begin
      shreg <= data;
      saved <= data;
    end else if (reload) begin
      shreg <= saved;
    end else if (shift) begin
      shreg <= {shreg[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = shreg[WIDTH-1];

endmodule

// File: rtl/seq_gen.sv
// Serial bit-pattern transmitter: takes a pattern and repeat count over a
// valid/ready handshake and sends it MSB-first with GAP idle cycles between frames.
module seq_gen
  import seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GAP   = DEF_GAP,
  parameter int REPW  = DEF_REPW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [REPW-1:0]  repeat_cnt,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int              CNTW     = $clog2(WIDTH);
  localparam logic [CNTW-1:0] LAST_BIT = CNTW'(WIDTH - 1);
  localparam logic [3:0]      GAP_LOAD = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  state_t          state, state_next;
  logic [CNTW-1:0] bit_cnt, bit_next;
  logic [REPW-1:0] rep_cnt, rep_next;
  logic [3:0]      gap_cnt, gap_next;
  logic            fire, do_shift, do_reload, msb;

  assign fire = load_valid && (state == S_IDLE);

  seq_shift #(.WIDTH(WIDTH)) u_shift (
    .clk    (clk),
    .reset  (reset),
    .load   (fire),
    .data   (load_data),
    .shift  (do_shift),
    .reload (do_reload),
    .msb    (msb)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      rep_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_next;
      rep_cnt <= rep_next;
      gap_cnt <= gap_next;
    end
  end

  // The last bit of a frame either reloads the pattern for another repetition or ends the transfer.
  always_comb begin
    state_next = state;
    bit_next   = bit_cnt;
    rep_next   = rep_cnt;
    gap_next   = gap_cnt;
    do_shift   = 1'b0;
    do_reload  = 1'b0;
    case (state)
      S_IDLE: begin
        if (fire) begin
          state_next = S_SEND;
          bit_next   = LAST_BIT;
          rep_next   = repeat_cnt;
        end
      end
      S_SEND: begin
        if (bit_cnt != '0) begin
          do_shift = 1'b1;
          bit_next = bit_cnt - CNTW'(1);
        end else if (rep_cnt != '0) begin
          do_reload  = 1'b1;
          rep_next   = rep_cnt - REPW'(1);
          bit_next   = LAST_BIT;
          gap_next   = GAP_LOAD;
          state_next = (GAP == 0) ? S_SEND : S_GAP;
        end else begin
          state_next = S_DONE;
        end
      end
      S_GAP: begin
        if (gap_cnt != '0) gap_next = gap_cnt - 4'd1;
        else               state_next = S_SEND;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign load_ready = (state == S_IDLE);
  assign x_valid    = (state == S_SEND);
  assign x          = x_valid & msb;
  assign busy       = (state == S_SEND) || (state == S_GAP);
  assign done       = (state == S_DONE);

endmodule

// File: doc/seq_gen.md
# seq_gen

Serial bit-pattern transmitter. It accepts a WIDTH-bit pattern and a repeat count over a valid/ready load handshake. It then drives the pattern MSB-first, one bit per clock, on a serial line with a qualifying strobe, inserting GAP idle cycles between repetitions. It is the driving end of the serial sequence-detector path and supplies stimulus frames to the detector blocks.

## Interface
- WIDTH, 4, pattern length in bits (2..16)
- GAP, 1, idle cycles between repetitions (0..15)
- REPW, 4, width of repeat_cnt
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- load_valid  input  1  pattern/count offered
- load_ready  output  1  block can accept a load
- load_data  input  WIDTH  pattern, MSB sent first
- repeat_cnt  input  REPW  extra repetitions (0 = send once)
- x  output  1  serial data bit
- x_valid  output  1  x carries a pattern bit this cycle
- busy  output  1  transfer in progress
- done  output  1  one-cycle pulse after the final bit

## Operation
- One clock (clk); reset is asynchronous and active-low. While reset is low: state=IDLE, x=0, x_valid=0, busy=0, done=0, load_ready=1, and all internal registers are cleared.
- FSM states: IDLE, SEND, GAP, DONE. Outputs are registered; Moore style.
- IDLE: load_ready=1. A load fires when load_valid && load_ready at a clock edge. On a fire: shift register ← load_data, bit counter ← WIDTH-1, rep counter ← repeat_cnt, next state SEND.
- SEND: x = shreg[WIDTH-1], x_valid=1, busy=1, load_ready=0. Each cycle the register shifts left by 1 and the bit counter decrements.
  - At bit counter 0 with rep counter ≠ 0: rep counter decrements, the pattern reloads from its saved copy, and the FSM goes to GAP. If GAP=0 it goes straight to SEND, giving back-to-back frames.
  - At bit counter 0 with rep counter = 0: go to DONE.
- GAP: x=0, x_valid=0, busy=1 for exactly GAP cycles, then SEND.
- DONE: done=1, busy=0, x_valid=0, load_ready=0 for one cycle, then IDLE.
- A saved copy of load_data is held for reloads. load_data changes after acceptance are ignored.
- load_valid in any state other than IDLE is ignored. It is not queued.
- x=0 whenever x_valid=0.
- Counter widths: bit counter is clog2(WIDTH) bits, gap counter is 4 bits, rep counter is REPW bits. None of them wraps. Each is compared against 0 before decrementing.

## Timing
- Latency: load fire at edge N puts the first bit on x after edge N, so it is valid during cycle N+1. A single frame occupies cycles N+1..N+WIDTH, and done is high in cycle N+WIDTH+1.
- load_ready returns high in cycle N+WIDTH+2. The earliest next fire is the edge ending that cycle.
- Total busy cycles = (repeat_cnt+1)·WIDTH + repeat_cnt·GAP.
- Reset asserted mid-frame: outputs return to their reset values immediately (asynchronously), with no done pulse. After release, the block sits in IDLE.
- Reset is released synchronously to the design by the system. No fire can occur on the first edge after release unless load_valid is high.

## Structure
- Shared package seq_pkg: state encoding (IDLE=0, SEND=1, GAP=2, DONE=3, 2-bit) and the default WIDTH/GAP/REPW constants.
- One sub-module, seq_shift: a WIDTH-bit parallel-load, left-shift register with a saved copy and reload input. The FSM and counters stay in seq_gen.

## Test plan
- Reset, then load 4'b1010 with repeat_cnt=0 → x_valid high 4 cycles with x=1,0,1,0; done pulses the next cycle; load_ready high the cycle after.
- Load 4'b1010 with repeat_cnt=2, GAP=1 → x=1010,0(invalid),1010,0(invalid),1010; busy for 14 cycles; a single done pulse.
- GAP=0, load 4'b1100 with repeat_cnt=1 → 8 consecutive valid bits 11001100.
- Hold load_valid high with changing load_data during SEND → the transmitted bits are unaffected; no second frame starts until load_ready is high.
- Assert reset low at the 2nd bit of a frame → x, x_valid, busy and done go to 0 immediately; load_ready=1 after release; no done pulse.
- WIDTH=8, load 8'hA5 → x=10100101, done at cycle 9 after the fire.
